// File: rtl/taxi_board_led_ctrl.sv
// Board status LED controller: per-port presence/fault/link/activity LEDs,
// a heartbeat LED and an aggregate fault LED, all registered.
module taxi_board_led_ctrl #(
   parameter int CNT         = 2,
   parameter int HB_COUNT    = 62500000,
   parameter int BLINK_W     = 24,
   parameter int SLOW_BIT    = 23,
   parameter int FAST_BIT    = 21,
   parameter int ACT_OFF_CYC = 4000000,
   parameter int ACT_ON_CYC  = 4000000,
   parameter int LED_ACT_LOW = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [CNT-1:0] present,
   input  logic [CNT-1:0] fault,
   input  logic [CNT-1:0] link,
   input  logic [CNT-1:0] act,
   output logic [CNT-1:0] led_port,
   output logic           led_hb,
   output logic           led_fault
);

   localparam int HB_W    = $clog2(HB_COUNT);
   localparam int TMR_MAX = (ACT_OFF_CYC > ACT_ON_CYC)
                            ? ((ACT_OFF_CYC > 2) ? ACT_OFF_CYC : 2)
                            : ((ACT_ON_CYC > 2) ? ACT_ON_CYC : 2);
   localparam int TMR_W   = $clog2(TMR_MAX);

   localparam logic              POL       = (LED_ACT_LOW != 0);
   localparam logic [HB_W-1:0]   HB_RELOAD = HB_W'(HB_COUNT - 1);
   localparam logic [TMR_W-1:0]  OFF_LOAD  = TMR_W'(ACT_OFF_CYC - 1);
   localparam logic [TMR_W-1:0]  ON_LOAD   = TMR_W'(ACT_ON_CYC - 1);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_FAULT,
      ST_NOLINK,
      ST_LINK_ON,
      ST_ACT_OFF,
      ST_ACT_ON
   } ch_state_t;

   logic [HB_W-1:0]    hb_cnt;
   logic               hb_phase;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_slow;
   logic               blink_fast;

   assign blink_slow = blink_cnt[SLOW_BIT];
   assign blink_fast = blink_cnt[FAST_BIT];

   function automatic logic led_value(input ch_state_t st, input logic fast, input logic slow);
      logic v;
      v = 1'b0;
      case (st)
         ST_FAULT:   v = fast;
         ST_NOLINK:  v = slow;
         ST_LINK_ON: v = 1'b1;
         ST_ACT_ON:  v = 1'b1;
         default:    v = 1'b0;
      endcase
      return v;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         hb_cnt   <= HB_RELOAD;
         hb_phase <= 1'b0;
         led_hb   <= POL;
      end else begin
         led_hb <= hb_phase ^ POL;
         if (hb_cnt == '0) begin
            hb_cnt   <= HB_RELOAD;
            hb_phase <= ~hb_phase;
         end else begin
            hb_cnt <= hb_cnt - HB_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         led_fault <= POL;
      end else begin
         blink_cnt <= blink_cnt + BLINK_W'(1);
         led_fault <= (|(present & fault)) ^ POL;
      end
   end

   for (genvar gi = 0; gi < CNT; gi++) begin : g_ch
      ch_state_t        state;
      logic [TMR_W-1:0] tmr;
      logic             pend;
      logic             led_q;

      // Presence, fault and link override the activity FSM in that order.
      always_ff @(posedge clk) begin
         if (rst) begin
            state <= ST_OFF;
            tmr   <= '0;
            pend  <= 1'b0;
            led_q <= POL;
         end else begin
            led_q <= led_value(state, blink_fast, blink_slow) ^ POL;
            if (!present[gi]) begin
               state <= ST_OFF;
               tmr   <= '0;
               pend  <= 1'b0;
            end else if (fault[gi]) begin
               state <= ST_FAULT;
               tmr   <= '0;
               pend  <= 1'b0;
            end else if (!link[gi]) begin
               state <= ST_NOLINK;
               tmr   <= '0;
               pend  <= 1'b0;
            end else begin
               case (state)
                  ST_LINK_ON: begin
                     if (act[gi] || pend) begin
                        state <= ST_ACT_OFF;
                        tmr   <= OFF_LOAD;
                        pend  <= 1'b0;
                     end
                  end
                  ST_ACT_OFF: begin
                     if (act[gi]) pend <= 1'b1;
                     if (tmr == '0) begin
                        state <= ST_ACT_ON;
                        tmr   <= ON_LOAD;
                     end else begin
                        tmr <= tmr - TMR_W'(1);
                     end
                  end
                  ST_ACT_ON: begin
                     if (act[gi]) pend <= 1'b1;
                     if (tmr == '0) begin
                        state <= ST_LINK_ON;
                     end else begin
                        tmr <= tmr - TMR_W'(1);
                     end
                  end
                  default: begin
                     state <= ST_LINK_ON;
                     tmr   <= '0;
                     pend  <= 1'b0;
                  end
               endcase
            end
         end
      end

      assign led_port[gi] = led_q;
   end

endmodule

// File: doc/taxi_board_led_ctrl.md
Name: taxi_board_led_ctrl

Overview:
- Parametrised board status LED controller for CNT network ports, plus one heartbeat LED and one aggregate fault LED.
- Each port LED encodes module presence, fault, link and traffic activity: off, blinking, steady on, or on with activity flashes.
- Sits in each board's fpga_core, driven by MAC rx_status, module present/fault pins and per-packet activity strobes. It replaces the hard-coded heartbeat counter and inverted rx_status LED assignments.

Parameters:
- CNT, 2, number of port LED channels (1..32).
- HB_COUNT, 62500000, heartbeat half-period in clk cycles (>=2).
- BLINK_W, 24, width of the free-running blink counter.
- SLOW_BIT, 23, blink counter bit used as the slow-blink phase (< BLINK_W).
- FAST_BIT, 21, blink counter bit used as the fast-blink phase (< SLOW_BIT).
- ACT_OFF_CYC, 4000000, activity flash off-time in cycles (>=1).
- ACT_ON_CYC, 4000000, minimum on-time between flashes in cycles (>=1).
- LED_ACT_LOW, 1, 1 means LED outputs are active-low.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- present  in  CNT  module present, active-high.
- fault  in  CNT  module tx fault, active-high.
- link  in  CNT  link up (MAC rx_status).
- act  in  CNT  single-cycle activity strobe per port.
- led_port  out  CNT  per-port LED drive.
- led_hb  out  1  heartbeat LED drive.
- led_fault  out  1  aggregate fault LED drive.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - All inputs are already synchronous to clk; the block adds no synchronisers.
  - All outputs are registered.
  - Reset values: every LED off, i.e. each output equals LED_ACT_LOW. Heartbeat phase 0, hb counter = HB_COUNT-1, blink counter 0, all channels in OFF, all pending flags 0.
- Heartbeat:
  - The down-counter decrements each cycle.
  - When it reaches 0 it reloads HB_COUNT-1 and the phase toggles.
  - led_hb = phase XOR LED_ACT_LOW.
  - The first toggle is visible HB_COUNT+1 cycles after rst deasserts (HB_COUNT cycles to the toggle plus 1 output register). After that the period is exactly 2*HB_COUNT cycles.
- Blink counter: free-running BLINK_W-bit up-counter that wraps to 0. slow = cnt[SLOW_BIT], fast = cnt[FAST_BIT].
- Per-channel state machine, evaluated every cycle in priority order:
  1. !present -> OFF.
  2. present & fault -> FAULT.
  3. present & !link -> NOLINK.
  4. Otherwise the link FSM runs.
- Link FSM states:
  - LINK_ON: on an act strobe or pending flag, go to ACT_OFF, load timer with ACT_OFF_CYC-1, clear pending.
  - ACT_OFF: at timer 0 go to ACT_ON and load ACT_ON_CYC-1; otherwise decrement.
  - ACT_ON: at timer 0 go to LINK_ON; otherwise decrement.
  - Entry into LINK_ON from OFF, FAULT or NOLINK happens when the higher conditions clear; timer and pending clear on that entry.
- Activity pending:
  - An act strobe during ACT_OFF or ACT_ON sets pending. Multiple strobes collapse into one flash.
  - An act strobe in LINK_ON is consumed directly.
  - An act strobe in OFF, FAULT or NOLINK is ignored.
- Link or present drop mid-flash: leave the link FSM immediately and clear timer and pending.
- LED value (before polarity):
  - OFF = 0, FAULT = fast, NOLINK = slow.
  - LINK_ON = 1, ACT_ON = 1, ACT_OFF = 0.
- LED latency:
  - led_port[i] = value XOR LED_ACT_LOW, registered: 1 cycle after the state register.
  - An act strobe in LINK_ON at cycle t gives the LED off at t+2.
  - The off-time lasts exactly ACT_OFF_CYC cycles.
- Aggregate fault: led_fault = (OR over i of present[i]&fault[i]) XOR LED_ACT_LOW, registered, 1-cycle latency.
- Timer widths: $clog2 of max(ACT_OFF_CYC, ACT_ON_CYC, 2). The hb counter width is $clog2(HB_COUNT).
- Reset mid-flash or mid-blink: returns to the reset values on the next edge. No residual pending.

Test Plan:
- Reset and heartbeat (LED_ACT_LOW=1, HB_COUNT=8): hold rst 3 cycles, release.
  - Required: all outputs 1.
  - Required: led_hb falls 9 cycles after release, then toggles every 8 cycles.
- Link states (CNT=2, FAST_BIT=1, SLOW_BIT=3):
  - present=0 -> led_port=1 (LED off).
  - present=1, link=0 -> led_port[0] toggles every 8 cycles.
  - fault=1 -> toggles every 2 cycles and led_fault=0.
  - fault=0, link=1 -> steady 0.
- Activity flash (ACT_OFF_CYC=4, ACT_ON_CYC=3): act[0] pulse at cycle t in LINK_ON.
  - Required: led_port[0] off during t+2..t+5, on at t+6.
  - Required: channel 1 unaffected.
- Pending collapse: 5 act strobes during ACT_OFF.
  - Required: after the 3-cycle ACT_ON, exactly one further 4-cycle flash, then steady on.
- Link drop mid-flash: link[0]=0 two cycles into ACT_OFF.
  - Required: next LED value follows slow blink.
  - Required: on link restore, LED steady on with no stale flash.
- Mid-operation reset: assert rst during FAULT blink with pending set.
  - Required: all outputs 1 one cycle later.
  - Required: counters restart; the heartbeat timing of the first scenario repeats.
